// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake engine: headings, FSM states, reversal.
package snake_pkg;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StCheck,
        StCommit,
        StOver
    } state_e;

    // Up<->down and left<->right differ only in bit 1 of the encoding.
    function automatic logic [1:0] reverse_dir(input logic [1:0] dir);
        return dir ^ 2'b10;
    endfunction

endpackage

// File: rtl/snake_next_head.sv
// Combinational next-head calculator with wall detection or toroidal wrap.
module snake_next_head
    import snake_pkg::*;
#(
    parameter int unsigned GRID_W = 40,
    parameter int unsigned GRID_H = 30,
    parameter int unsigned XW     = 6,
    parameter int unsigned YW     = 5,
    parameter int unsigned WRAP   = 0
) (
    input  logic [XW-1:0] cur_x_i,
    input  logic [YW-1:0] cur_y_i,
    input  logic [1:0]    dir_i,
    output logic [XW-1:0] nxt_x_o,
    output logic [YW-1:0] nxt_y_o,
    output logic          out_of_bounds_o
);

    localparam logic [XW-1:0] XMax = XW'(GRID_W - 1);
    localparam logic [YW-1:0] YMax = YW'(GRID_H - 1);
    localparam logic          Kill = (WRAP == 0);

    // Step one cell; at an edge either flag the wall or wrap to the grid's far side.
    always_comb begin
        nxt_x_o         = cur_x_i;
        nxt_y_o         = cur_y_i;
        out_of_bounds_o = 1'b0;
        case (dir_i)
            DIR_UP: begin
                if (cur_y_i == '0) begin
                    nxt_y_o         = YMax;
                    out_of_bounds_o = Kill;
                end else begin
                    nxt_y_o = cur_y_i - 1'b1;
                end
            end
            DIR_RIGHT: begin
                if (cur_x_i >= XMax) begin
                    nxt_x_o         = '0;
                    out_of_bounds_o = Kill;
                end else begin
                    nxt_x_o = cur_x_i + 1'b1;
                end
            end
            DIR_DOWN: begin
                if (cur_y_i >= YMax) begin
                    nxt_y_o         = '0;
                    out_of_bounds_o = Kill;
                end else begin
                    nxt_y_o = cur_y_i + 1'b1;
                end
            end
            default: begin
                if (cur_x_i == '0) begin
                    nxt_x_o         = XMax;
                    out_of_bounds_o = Kill;
                end else begin
                    nxt_x_o = cur_x_i - 1'b1;
                end
            end
        endcase
    end

endmodule

// File: rtl/snake_engine.sv
// Snake state engine: segment store, move/collision FSM, growth and renderer query port.
module snake_engine
    import snake_pkg::*;
#(
    parameter int unsigned MAX_LEN = 32,
    parameter int unsigned GRID_W  = 40,
    parameter int unsigned GRID_H  = 30,
    parameter int unsigned XW      = 6,
    parameter int unsigned YW      = 5,
    parameter int unsigned START_X = 20,
    parameter int unsigned START_Y = 15,
    parameter int unsigned WRAP    = 0,
    localparam int unsigned LW     = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          move_tick,
    input  logic [1:0]    dir_req,
    input  logic [XW-1:0] apple_x,
    input  logic [YW-1:0] apple_y,
    input  logic [XW-1:0] query_x,
    input  logic [YW-1:0] query_y,
    output logic          query_head,
    output logic          query_body,
    output logic [XW-1:0] head_x,
    output logic [YW-1:0] head_y,
    output logic [LW-1:0] length,
    output logic          apple_eaten,
    output logic          game_over,
    output logic          busy,
    output logic          tick_overrun
);

    localparam logic [XW-1:0] StartX = XW'(START_X);
    localparam logic [YW-1:0] StartY = YW'(START_Y);
    localparam logic [LW-1:0] LenOne = LW'(1);
    localparam logic [LW-1:0] LenMax = LW'(MAX_LEN);

    state_e        state_q, state_d;
    logic [XW-1:0] seg_x_q [MAX_LEN];
    logic [XW-1:0] seg_x_d [MAX_LEN];
    logic [YW-1:0] seg_y_q [MAX_LEN];
    logic [YW-1:0] seg_y_d [MAX_LEN];
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] idx_q, idx_d;
    logic [1:0]    heading_q, heading_d;
    logic [XW-1:0] nxt_x_q, nxt_x_d;
    logic [YW-1:0] nxt_y_q, nxt_y_d;
    logic          eat_q, eat_d;
    logic          overrun_q, overrun_d;
    logic          query_head_q, query_head_d;
    logic          query_body_q, query_body_d;

    logic [1:0]    dir_sel;
    logic [XW-1:0] step_x;
    logic [YW-1:0] step_y;
    logic          step_oob;
    logic [LW-1:0] scan_lim;
    logic [XW-1:0] scan_x;
    logic [YW-1:0] scan_y;
    logic          scan_hit;
    logic          is_busy;
    logic          head_hit;
    logic          body_hit;

    // A one-segment snake may turn around; a longer one ignores reversal requests.
    assign dir_sel = ((dir_req == reverse_dir(heading_q)) && (len_q > LenOne)) ? heading_q
                                                                                : dir_req;

    snake_next_head #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H),
        .XW     (XW),
        .YW     (YW),
        .WRAP   (WRAP)
    ) u_next_head (
        .cur_x_i         (seg_x_q[0]),
        .cur_y_i         (seg_y_q[0]),
        .dir_i           (dir_sel),
        .nxt_x_o         (step_x),
        .nxt_y_o         (step_y),
        .out_of_bounds_o (step_oob)
    );

    // The tail cell vacates on a plain move, so it is excluded from the scan.
    assign scan_lim = eat_q ? len_q : len_q - LenOne;
    assign is_busy  = (state_q == StCheck) || (state_q == StCommit);

    // Select the segment under test for the sequential collision scan.
    always_comb begin
        scan_x = seg_x_q[0];
        scan_y = seg_y_q[0];
        for (int i = 0; i < MAX_LEN; i++) begin
            if (LW'(i) == idx_q) begin
                scan_x = seg_x_q[i];
                scan_y = seg_y_q[i];
            end
        end
    end

    assign scan_hit = (scan_x == nxt_x_q) && (scan_y == nxt_y_q);

    // Move FSM next-state, segment shifting and growth.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        heading_d = heading_q;
        nxt_x_d   = nxt_x_q;
        nxt_y_d   = nxt_y_q;
        eat_d     = eat_q;
        overrun_d = overrun_q;
        for (int i = 0; i < MAX_LEN; i++) begin
            seg_x_d[i] = seg_x_q[i];
            seg_y_d[i] = seg_y_q[i];
        end

        if (start) begin
            state_d    = StRun;
            len_d      = LenOne;
            idx_d      = '0;
            heading_d  = DIR_RIGHT;
            eat_d      = 1'b0;
            overrun_d  = 1'b0;
            seg_x_d[0] = StartX;
            seg_y_d[0] = StartY;
        end else begin
            if (move_tick && is_busy) begin
                overrun_d = 1'b1;
            end
            case (state_q)
                StRun: begin
                    if (move_tick) begin
                        if (step_oob) begin
                            state_d = StOver;
                        end else begin
                            state_d   = StCheck;
                            heading_d = dir_sel;
                            nxt_x_d   = step_x;
                            nxt_y_d   = step_y;
                            eat_d     = (step_x == apple_x) && (step_y == apple_y);
                            idx_d     = '0;
                        end
                    end
                end
                StCheck: begin
                    if (scan_lim == '0) begin
                        state_d = StCommit;
                    end else if (scan_hit) begin
                        state_d = StOver;
                    end else if (idx_q == scan_lim - LenOne) begin
                        state_d = StCommit;
                    end else begin
                        idx_d = idx_q + LenOne;
                    end
                end
                StCommit: begin
                    // Slots at or beyond length are masked, so shifting every slot is safe.
                    for (int k = 1; k < MAX_LEN; k++) begin
                        seg_x_d[k] = seg_x_q[k-1];
                        seg_y_d[k] = seg_y_q[k-1];
                    end
                    seg_x_d[0] = nxt_x_q;
                    seg_y_d[0] = nxt_y_q;
                    if (eat_q && (len_q != LenMax)) begin
                        len_d = len_q + LenOne;
                    end
                    state_d = StRun;
                end
                StIdle, StOver: begin
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Renderer lookup over all live segments; head wins over body.
    always_comb begin
        head_hit = 1'b0;
        body_hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((LW'(i) < len_q) && (seg_x_q[i] == query_x) && (seg_y_q[i] == query_y)) begin
                if (i == 0) begin
                    head_hit = 1'b1;
                end else begin
                    body_hit = 1'b1;
                end
            end
        end
        query_head_d = head_hit;
        query_body_d = body_hit & ~head_hit;
    end

    // State and segment registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            len_q        <= LenOne;
            idx_q        <= '0;
            heading_q    <= DIR_RIGHT;
            nxt_x_q      <= '0;
            nxt_y_q      <= '0;
            eat_q        <= 1'b0;
            overrun_q    <= 1'b0;
            query_head_q <= 1'b0;
            query_body_q <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= '0;
                seg_y_q[i] <= '0;
            end
            seg_x_q[0]   <= StartX;
            seg_y_q[0]   <= StartY;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            heading_q    <= heading_d;
            nxt_x_q      <= nxt_x_d;
            nxt_y_q      <= nxt_y_d;
            eat_q        <= eat_d;
            overrun_q    <= overrun_d;
            query_head_q <= query_head_d;
            query_body_q <= query_body_d;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= seg_x_d[i];
                seg_y_q[i] <= seg_y_d[i];
            end
        end
    end

    assign head_x       = seg_x_q[0];
    assign head_y       = seg_y_q[0];
    assign length       = len_q;
    assign apple_eaten  = (state_q == StCommit) && eat_q;
    assign game_over    = (state_q == StOver);
    assign busy         = is_busy;
    assign tick_overrun = overrun_q;
    assign query_head   = query_head_q;
    assign query_body   = query_body_q;

endmodule

// File: tb/tb_snake_engine.sv
// Directed bench for snake_engine: a kill-wall instance (MAX_LEN 32) and a wrap instance
// (MAX_LEN 4) share stimulus; expectations are queued then compared when the DUT settles.
module tb_snake_engine;

    logic       clk = 1'b0;
    logic       reset, start, move_tick;
    logic [1:0] dir_req;
    logic [5:0] apple_x, query_x;
    logic [4:0] apple_y, query_y;

    logic       qh0, qb0, eaten0, over0, busy0, ovr0;
    logic [5:0] hx0;
    logic [4:0] hy0;
    logic [5:0] len0;
    logic       qh1, qb1, eaten1, over1, busy1, ovr1;
    logic [5:0] hx1;
    logic [4:0] hy1;
    logic [2:0] len1;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    localparam int HX0 = 0, HY0 = 1, LEN0 = 2, EAT0 = 3, OVER0 = 4, BUSY0 = 5, OVR0 = 6;
    localparam int QH0 = 7, QB0 = 8;
    localparam int HX1 = 10, HY1 = 11, LEN1 = 12, OVER1 = 14, BUSY1 = 15, QH1 = 17, QB1 = 18;
    localparam int PULSES = 20;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    snake_engine u_dut0 (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .move_tick    (move_tick),
        .dir_req      (dir_req),
        .apple_x      (apple_x),
        .apple_y      (apple_y),
        .query_x      (query_x),
        .query_y      (query_y),
        .query_head   (qh0),
        .query_body   (qb0),
        .head_x       (hx0),
        .head_y       (hy0),
        .length       (len0),
        .apple_eaten  (eaten0),
        .game_over    (over0),
        .busy         (busy0),
        .tick_overrun (ovr0)
    );

    snake_engine #(
        .MAX_LEN (4),
        .WRAP    (1)
    ) u_dut1 (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .move_tick    (move_tick),
        .dir_req      (dir_req),
        .apple_x      (apple_x),
        .apple_y      (apple_y),
        .query_x      (query_x),
        .query_y      (query_y),
        .query_head   (qh1),
        .query_body   (qb1),
        .head_x       (hx1),
        .head_y       (hy1),
        .length       (len1),
        .apple_eaten  (eaten1),
        .game_over    (over1),
        .busy         (busy1),
        .tick_overrun (ovr1)
    );

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            HX0:     return 32'(hx0);
            HY0:     return 32'(hy0);
            LEN0:    return 32'(len0);
            EAT0:    return 32'(eaten0);
            OVER0:   return 32'(over0);
            BUSY0:   return 32'(busy0);
            OVR0:    return 32'(ovr0);
            QH0:     return 32'(qh0);
            QB0:     return 32'(qb0);
            HX1:     return 32'(hx1);
            HY1:     return 32'(hy1);
            LEN1:    return 32'(len1);
            OVER1:   return 32'(over1);
            BUSY1:   return 32'(busy1);
            QH1:     return 32'(qh1);
            QB1:     return 32'(qb1);
            PULSES:  return 32'(pulses);
            default: return 32'hdead_beef;
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sel, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic check_all();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sel);
            checks++;
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic tick(input logic [1:0] d);
        dir_req   = d;
        move_tick = 1'b1;
        step();
        move_tick = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy0 || busy1) && n < 200) begin
            step();
            n++;
        end
        checks++;
        assert (n < 200) else begin
            errors++;
            $error("FAIL wait_idle observed=%0d cycles required<200", n);
        end
    endtask

    task automatic move(input logic [1:0] d);
        tick(d);
        wait_idle();
    endtask

    task automatic set_apple(input int x, input int y);
        apple_x = 6'(x);
        apple_y = 5'(y);
    endtask

    task automatic set_query(input int x, input int y);
        query_x = 6'(x);
        query_y = 5'(y);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; move_tick = 1'b0; dir_req = 2'd1;
        set_apple(0, 0);
        set_query(20, 15);
        step();
        step();
        // Reset values
        expect_val("rst_hx", HX0, 20);
        expect_val("rst_hy", HY0, 15);
        expect_val("rst_len", LEN0, 1);
        expect_val("rst_over", OVER0, 0);
        expect_val("rst_busy", BUSY0, 0);
        expect_val("rst_ovr", OVR0, 0);
        expect_val("rst_eat", EAT0, 0);
        expect_val("rst_qh", QH0, 0);
        check_all();
        reset = 1'b0;
        step();
        expect_val("idle_qh", QH0, 1);
        expect_val("idle_qb", QB0, 0);
        check_all();
        // IDLE ignores ticks
        tick(2'd1);
        step();
        step();
        expect_val("idle_tick_hx", HX0, 20);
        expect_val("idle_tick_busy", BUSY0, 0);
        check_all();

        // Three moves right, first one timed
        do_start();
        tick(2'd1);
        expect_val("mv_c1_hx", HX0, 20);
        expect_val("mv_c1_busy", BUSY0, 1);
        check_all();
        step();
        expect_val("mv_c2_hx", HX0, 20);
        expect_val("mv_c2_busy", BUSY0, 1);
        check_all();
        step();
        expect_val("mv_c3_hx", HX0, 21);
        expect_val("mv_c3_busy", BUSY0, 0);
        check_all();
        move(2'd1);
        move(2'd1);
        expect_val("mv3_hx", HX0, 23);
        expect_val("mv3_hy", HY0, 15);
        expect_val("mv3_len", LEN0, 1);
        check_all();

        // Apple capture and body query
        do_start();
        set_apple(21, 15);
        tick(2'd1);
        step();
        expect_val("eat_pulse", EAT0, 1);
        check_all();
        step();
        set_query(20, 15);
        expect_val("eat_pulse_end", EAT0, 0);
        expect_val("eat_len", LEN0, 2);
        expect_val("eat_hx", HX0, 21);
        check_all();
        step();
        expect_val("eat_qb_seg1", QB0, 1);
        expect_val("eat_qh_seg1", QH0, 0);
        check_all();
        set_query(21, 15);
        step();
        expect_val("eat_qh_head", QH0, 1);
        expect_val("eat_qb_head", QB0, 0);
        check_all();

        // Reversal rejected at length 3
        set_apple(22, 15);
        move(2'd1);
        set_apple(5, 5);
        move(2'd3);
        expect_val("rev_hx", HX0, 23);
        expect_val("rev_hy", HY0, 15);
        expect_val("rev_len", LEN0, 3);
        check_all();

        // Kill wall on the right edge; wrap instance crosses to column 0
        do_start();
        repeat (5) move(2'd0);
        repeat (19) move(2'd1);
        expect_val("wall_pre_hx", HX0, 39);
        expect_val("wall_pre_hy", HY0, 10);
        expect_val("wall_pre_over", OVER0, 0);
        check_all();
        tick(2'd1);
        expect_val("wall_over", OVER0, 1);
        expect_val("wall_busy", BUSY0, 0);
        expect_val("wall_hx", HX0, 39);
        expect_val("wall_hy", HY0, 10);
        check_all();
        wait_idle();
        expect_val("wrapx_hx1", HX1, 0);
        expect_val("wrapx_hy1", HY1, 10);
        check_all();
        tick(2'd1);
        step();
        step();
        expect_val("over_frozen_hx", HX0, 39);
        expect_val("over_frozen", OVER0, 1);
        expect_val("over_no_ovr", OVR0, 0);
        check_all();
        do_start();
        expect_val("restart_over", OVER0, 0);
        expect_val("restart_hx", HX0, 20);
        expect_val("restart_hy", HY0, 15);
        check_all();

        // Wrap instance: head (0,0) heading up wraps to the bottom row
        repeat (15) move(2'd0);
        repeat (20) move(2'd3);
        move(2'd0);
        expect_val("wrapy_hx1", HX1, 0);
        expect_val("wrapy_hy1", HY1, 29);
        expect_val("wrapy_over1", OVER1, 0);
        expect_val("wrapy_len1", LEN1, 1);
        check_all();

        // Self-collision on segment 3 after four CHECK cycles, with an overrun tick
        do_start();
        for (int i = 21; i <= 24; i++) begin
            set_apple(i, 15);
            move(2'd1);
        end
        set_apple(5, 5);
        expect_val("coll_len", LEN0, 5);
        expect_val("coll_hx", HX0, 24);
        check_all();
        move(2'd0);
        move(2'd3);
        tick(2'd2);
        expect_val("coll_c1_busy", BUSY0, 1);
        check_all();
        tick(2'd2);
        expect_val("coll_ovr", OVR0, 1);
        expect_val("coll_c2_over", OVER0, 0);
        check_all();
        step();
        step();
        expect_val("coll_c4_over", OVER0, 0);
        expect_val("coll_c4_busy", BUSY0, 1);
        check_all();
        step();
        set_query(24, 15);
        expect_val("coll_over", OVER0, 1);
        expect_val("coll_busy", BUSY0, 0);
        expect_val("coll_hx_frozen", HX0, 23);
        expect_val("coll_hy_frozen", HY0, 14);
        expect_val("coll_len_frozen", LEN0, 5);
        check_all();
        step();
        expect_val("coll_qb_seg2", QB0, 1);
        expect_val("coll_qh_seg2", QH0, 0);
        check_all();

        // Start and tick together: start wins and clears the overrun flag
        start = 1'b1;
        move_tick = 1'b1;
        dir_req = 2'd1;
        step();
        start = 1'b0;
        move_tick = 1'b0;
        expect_val("st_tick_busy0", BUSY0, 0);
        expect_val("st_tick_busy1", BUSY1, 0);
        expect_val("st_tick_ovr", OVR0, 0);
        expect_val("st_tick_hx", HX0, 20);
        check_all();

        // Growth saturates at MAX_LEN=4 on the wrap instance
        for (int i = 21; i <= 23; i++) begin
            set_apple(i, 15);
            move(2'd1);
        end
        expect_val("max_len_pre", LEN1, 4);
        check_all();
        set_apple(24, 15);
        tick(2'd1);
        for (int n = 0; n < 20; n++) begin
            if (eaten1) pulses++;
            if (!busy1) break;
            step();
        end
        set_query(21, 15);
        expect_val("max_pulses", PULSES, 1);
        expect_val("max_len", LEN1, 4);
        expect_val("max_hx", HX1, 24);
        check_all();
        step();
        expect_val("max_qb_tail", QB1, 1);
        check_all();
        set_query(20, 15);
        step();
        expect_val("max_qb_shifted", QB1, 0);
        expect_val("max_qh_shifted", QH1, 0);
        check_all();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
